// File: rtl/ssram_ft_ctrl_if.sv
// Host-side command, write-data and read-return channels of the flow-through SSRAM controller.
interface ssram_ft_ctrl_if #(
    parameter int ADDR_W = 16
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_we;
    logic              cmd_len4;
    logic [ADDR_W-1:0] cmd_addr;
    logic              wd_valid;
    logic              wd_ready;
    logic [17:0]       wd_data;
    logic [1:0]        wd_be;
    logic              rd_valid;
    logic [17:0]       rd_data;
    logic              sleep_req;

    modport master (
        output cmd_valid, cmd_we, cmd_len4, cmd_addr,
        output wd_valid, wd_data, wd_be, sleep_req,
        input  cmd_ready, wd_ready, rd_valid, rd_data
    );

    modport slave (
        input  cmd_valid, cmd_we, cmd_len4, cmd_addr,
        input  wd_valid, wd_data, wd_be, sleep_req,
        output cmd_ready, wd_ready, rd_valid, rd_data
    );
endinterface

// File: rtl/ssram_ft_ctrl.sv
// Burst controller for a CY7C1297H flow-through x18 SSRAM: ADSC/ADV linear bursts,
// write suspend on host backpressure, read/write turnaround and ZZ sleep sequencing.
module ssram_ft_ctrl #(
    parameter int ADDR_W   = 16,
    parameter int WAKE_CYC = 2
) (
    input  logic              CLK,
    input  logic              RST,
    ssram_ft_ctrl_if.slave    host,
    output logic [ADDR_W-1:0] ADDR,
    output logic              ADSC_N,
    output logic              ADSP_N,
    output logic              ADV_N,
    output logic              GW_N,
    output logic              BWE_N,
    output logic              BWa_N,
    output logic              BWb_N,
    output logic              CE1_N,
    output logic              CE2,
    output logic              CE3_N,
    output logic              OE_N,
    output logic              ZZ,
    output logic              MODE,
    output logic [17:0]       DQ_out,
    output logic              DQ_oe,
    input  logic [17:0]       DQ_in
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WR,
        S_TURN,
        S_SLEEP,
        S_WAKE
    } state_t;

    state_t            r_state;
    logic [1:0]        r_beat;
    logic              r_len4;
    logic [ADDR_W-1:0] r_addr;
    logic [3:0]        r_wcnt;
    logic [17:0]       r_cap;
    logic              r_cap_v;

    logic w_cmd_acc;
    logic w_wd_acc;
    logic w_wr_last;
    logic w_rd_cyc;

    assign w_cmd_acc = host.cmd_valid && host.cmd_ready;
    assign w_wd_acc  = host.wd_valid && host.wd_ready;
    assign w_wr_last = (r_beat == (r_len4 ? 2'd3 : 2'd0));
    // Flow-through: the word for a read address cycle is on DQ_in before the closing edge.
    assign w_rd_cyc  = (!ADSC_N || !ADV_N) && !OE_N;

    always_ff @(posedge CLK) begin
        ADSP_N <= 1'b1;
        GW_N   <= 1'b1;
        MODE   <= 1'b0;
        CE2    <= 1'b1;
        CE3_N  <= 1'b0;
        if (RST) begin
            r_state        <= S_IDLE;
            r_beat         <= '0;
            r_len4         <= 1'b0;
            r_addr         <= '0;
            r_wcnt         <= '0;
            r_cap          <= '0;
            r_cap_v        <= 1'b0;
            ADDR           <= '0;
            ADSC_N         <= 1'b1;
            ADV_N          <= 1'b1;
            BWE_N          <= 1'b1;
            BWa_N          <= 1'b1;
            BWb_N          <= 1'b1;
            CE1_N          <= 1'b1;
            OE_N           <= 1'b1;
            ZZ             <= 1'b0;
            DQ_out         <= '0;
            DQ_oe          <= 1'b0;
            host.cmd_ready <= 1'b0;
            host.wd_ready  <= 1'b0;
            host.rd_valid  <= 1'b0;
            host.rd_data   <= '0;
        end else begin
            ADSC_N <= 1'b1;
            ADV_N  <= 1'b1;
            BWE_N  <= 1'b1;
            BWa_N  <= 1'b1;
            BWb_N  <= 1'b1;
            CE1_N  <= 1'b1;
            DQ_oe  <= 1'b0;

            r_cap_v <= w_rd_cyc;
            if (w_rd_cyc) begin
                r_cap <= DQ_in;
            end
            host.rd_valid <= r_cap_v;
            if (r_cap_v) begin
                host.rd_data <= r_cap;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_cmd_acc) begin
                        host.cmd_ready <= 1'b0;
                        r_len4         <= host.cmd_len4;
                        if (host.cmd_we) begin
                            r_state       <= S_WR;
                            r_addr        <= host.cmd_addr;
                            r_beat        <= '0;
                            host.wd_ready <= 1'b1;
                        end else begin
                            r_state <= S_RD;
                            ADSC_N  <= 1'b0;
                            CE1_N   <= 1'b0;
                            ADDR    <= host.cmd_addr;
                            OE_N    <= 1'b0;
                            r_beat  <= host.cmd_len4 ? 2'd3 : 2'd0;
                        end
                    end else if (host.sleep_req) begin
                        r_state        <= S_SLEEP;
                        ZZ             <= 1'b1;
                        host.cmd_ready <= 1'b0;
                    end else begin
                        host.cmd_ready <= 1'b1;
                    end
                end

                S_RD: begin
                    if (r_beat != 2'd0) begin
                        ADV_N  <= 1'b0;
                        r_beat <= r_beat - 2'd1;
                    end else begin
                        OE_N    <= 1'b1;
                        r_state <= S_TURN;
                    end
                end

                S_WR: begin
                    if (host.wd_ready) begin
                        if (w_wd_acc) begin
                            BWE_N  <= 1'b0;
                            BWa_N  <= ~host.wd_be[0];
                            BWb_N  <= ~host.wd_be[1];
                            DQ_out <= host.wd_data;
                            DQ_oe  <= 1'b1;
                            if (r_beat == 2'd0) begin
                                ADSC_N <= 1'b0;
                                CE1_N  <= 1'b0;
                                ADDR   <= r_addr;
                            end else begin
                                ADV_N <= 1'b0;
                            end
                            if (w_wr_last) begin
                                host.wd_ready <= 1'b0;
                            end else begin
                                r_beat <= r_beat + 2'd1;
                            end
                        end
                    end else begin
                        // Final beat is on the pins this cycle; TURN follows it.
                        r_state <= S_TURN;
                    end
                end

                S_TURN: begin
                    r_state        <= S_IDLE;
                    host.cmd_ready <= ~host.sleep_req;
                end

                S_SLEEP: begin
                    if (!host.sleep_req) begin
                        r_state <= S_WAKE;
                        ZZ      <= 1'b0;
                        r_wcnt  <= 4'(WAKE_CYC - 1);
                    end
                end

                S_WAKE: begin
                    if (host.sleep_req) begin
                        r_state <= S_SLEEP;
                        ZZ      <= 1'b1;
                    end else if (r_wcnt == 4'd0) begin
                        r_state        <= S_IDLE;
                        host.cmd_ready <= 1'b1;
                    end else begin
                        r_wcnt <= r_wcnt - 4'd1;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ssram_ft_ctrl.sv
// Directed bench for ssram_ft_ctrl with a behavioural flow-through x18 SSRAM on the pins.
module tb_ssram_ft_ctrl;

    localparam logic [16:0] RST_PINS = 17'b1_1_1_1_1_1_1_1_1_0_0_1_0_0_0_0_0;

    logic        CLK;
    logic        RST;
    logic [15:0] ADDR;
    logic        ADSC_N, ADSP_N, ADV_N, GW_N, BWE_N, BWa_N, BWb_N;
    logic        CE1_N, CE2, CE3_N, OE_N, ZZ, MODE, DQ_oe;
    logic [17:0] DQ_out;
    logic [17:0] DQ_in;

    ssram_ft_ctrl_if #(.ADDR_W(16)) bus ();

    ssram_ft_ctrl #(.ADDR_W(16), .WAKE_CYC(2)) dut (
        .CLK(CLK), .RST(RST), .host(bus),
        .ADDR(ADDR), .ADSC_N(ADSC_N), .ADSP_N(ADSP_N), .ADV_N(ADV_N), .GW_N(GW_N),
        .BWE_N(BWE_N), .BWa_N(BWa_N), .BWb_N(BWb_N), .CE1_N(CE1_N), .CE2(CE2),
        .CE3_N(CE3_N), .OE_N(OE_N), .ZZ(ZZ), .MODE(MODE),
        .DQ_out(DQ_out), .DQ_oe(DQ_oe), .DQ_in(DQ_in)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int viol     = 0;
    logic prev_oe_n = 1'b1;
    int          q_cyc[$];
    logic [17:0] q_dat[$];

    logic [16:0] w_pins;
    assign w_pins = {ADSC_N, ADSP_N, ADV_N, GW_N, BWE_N, BWa_N, BWb_N, CE1_N, OE_N,
                     ZZ, MODE, CE2, CE3_N, DQ_oe, bus.cmd_ready, bus.wd_ready, bus.rd_valid};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // SSRAM model: linear burst counter in the low two address bits, data flows through
    // combinationally for the address presented in the current pin cycle.
    logic [17:0] mem [0:255];
    logic [15:0] m_cur;
    logic [15:0] m_addr;

    always_comb begin
        m_addr = m_cur;
        if (!ADSC_N)     m_addr = ADDR;
        else if (!ADV_N) m_addr = {m_cur[15:2], m_cur[1:0] + 2'd1};
    end
    assign DQ_in = OE_N ? 18'h0 : mem[m_addr[7:0]];

    always @(posedge CLK) begin
        if (RST && cyc < 4) begin
            for (int i = 0; i < 256; i++) mem[i] <= '0;
            m_cur <= '0;
        end else if (!ZZ && (!ADSC_N || !ADV_N)) begin
            m_cur <= m_addr;
            if (!BWE_N) begin
                if (!BWa_N) mem[m_addr[7:0]][8:0]  <= DQ_out[8:0];
                if (!BWb_N) mem[m_addr[7:0]][17:9] <= DQ_out[17:9];
            end
        end
    end

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        if (!RST) begin
            if ((!OE_N && DQ_oe) || (DQ_oe && !prev_oe_n)) viol++;
            prev_oe_n = OE_N;
            if (bus.rd_valid) begin
                q_cyc.push_back(cyc);
                q_dat.push_back(bus.rd_data);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Called at a negedge; returns at the negedge after the acceptance edge.
    task automatic do_cmd(input logic we, input logic len4, input logic [15:0] addr, output int t);
        int n = 0;
        while (!bus.cmd_ready && n < 20) begin
            @(negedge CLK);
            n++;
        end
        check_eq("cmd_ready_wait", bus.cmd_ready, 1);
        bus.cmd_valid = 1'b1;
        bus.cmd_we    = we;
        bus.cmd_len4  = len4;
        bus.cmd_addr  = addr;
        t = cyc + 1;
        @(negedge CLK);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wr_beat(input int k, input logic [15:0] addr, input logic [17:0] d,
                           input logic [1:0] be);
        int n = 0;
        bus.wd_valid = 1'b1;
        bus.wd_data  = d;
        bus.wd_be    = be;
        while (!bus.wd_ready && n < 20) begin
            @(negedge CLK);
            n++;
        end
        check_eq($sformatf("wd_ready_b%0d", k), bus.wd_ready, 1);
        @(negedge CLK);
        bus.wd_valid = 1'b0;
        check_eq($sformatf("wr_pins_b%0d", k), {ADSC_N, ADV_N, BWE_N, BWa_N, BWb_N, DQ_oe, OE_N},
                 {(k == 0) ? 1'b0 : 1'b1, (k == 0) ? 1'b1 : 1'b0, 1'b0, ~be[0], ~be[1], 1'b1, 1'b1});
        check_eq($sformatf("wr_data_b%0d", k), DQ_out, d);
        if (k == 0) check_eq("wr_addr", ADDR, addr);
    endtask

    task automatic rd_expect(input string tag, input int t, input int n,
                             input logic [3:0][17:0] e);
        for (int b = 0; b < n; b++) begin
            int w = 0;
            while (q_dat.size() == 0 && w < 12) begin
                @(negedge CLK);
                #1;
                w++;
            end
            check_eq($sformatf("%s_present_b%0d", tag, b), q_dat.size() > 0, 1);
            if (q_dat.size() > 0) begin
                check_eq($sformatf("%s_lat_b%0d", tag, b), q_cyc.pop_front(), t + 2 + b);
                check_eq($sformatf("%s_data_b%0d", tag, b), q_dat.pop_front(), e[b]);
            end
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!bus.cmd_ready && n < 20) begin
            @(negedge CLK);
            n++;
        end
    endtask

    initial begin
        int t1, t2;
        RST = 1'b1;
        bus.cmd_valid = 0; bus.cmd_we = 0; bus.cmd_len4 = 0; bus.cmd_addr = '0;
        bus.wd_valid = 0; bus.wd_data = '0; bus.wd_be = '0; bus.sleep_req = 0;

        repeat (3) @(negedge CLK);
        check_eq("rst_pins", w_pins, RST_PINS);
        check_eq("rst_addr_dq", {ADDR, DQ_out}, '0);
        check_eq("rst_rd_data", bus.rd_data, 0);
        RST = 1'b0;
        @(negedge CLK);
        check_eq("rel_cmd_ready", bus.cmd_ready, 1);

        // Single write then single read of the same word.
        do_cmd(1'b1, 1'b0, 16'h0005, t1);
        check_eq("wr_ready_on", bus.wd_ready, 1);
        wr_beat(0, 16'h0005, 18'h2A5A5, 2'b11);
        @(negedge CLK);
        check_eq("turn_pins", {OE_N, DQ_oe, bus.cmd_ready, bus.wd_ready}, 4'b1000);
        @(negedge CLK);
        check_eq("turn_to_idle", bus.cmd_ready, 1);
        do_cmd(1'b0, 1'b0, 16'h0005, t1);
        rd_expect("rd5", t1, 1, {54'h0, 18'h2A5A5});

        // 4-beat write with a two-cycle suspend after beat 1, then readbacks incl. wrap.
        do_cmd(1'b1, 1'b1, 16'h0012, t1);
        wr_beat(0, 16'h0012, 18'd1, 2'b11);
        wr_beat(1, 16'h0012, 18'd2, 2'b11);
        repeat (2) begin
            @(negedge CLK);
            check_eq("suspend_pins", {ADSC_N, ADV_N, BWE_N, DQ_oe}, 4'b1110);
        end
        wr_beat(2, 16'h0012, 18'd3, 2'b11);
        wr_beat(3, 16'h0012, 18'd4, 2'b11);
        do_cmd(1'b0, 1'b1, 16'h0012, t1);
        rd_expect("rd12", t1, 4, {18'd4, 18'd3, 18'd2, 18'd1});
        do_cmd(1'b0, 1'b1, 16'h0013, t1);
        rd_expect("rd13", t1, 4, {18'd1, 18'd4, 18'd3, 18'd2});

        // Byte-a write over a zero word.
        do_cmd(1'b1, 1'b0, 16'h0020, t1);
        wr_beat(0, 16'h0020, 18'h3FFFF, 2'b01);
        do_cmd(1'b0, 1'b0, 16'h0020, t1);
        rd_expect("rd20", t1, 1, {54'h0, 18'h001FF});

        // Read burst immediately followed by a write command.
        do_cmd(1'b0, 1'b1, 16'h0012, t1);
        do_cmd(1'b1, 1'b0, 16'h0030, t2);
        wr_beat(0, 16'h0030, 18'h15555, 2'b11);
        rd_expect("rdw", t1, 4, {18'd4, 18'd3, 18'd2, 18'd1});
        do_cmd(1'b0, 1'b0, 16'h0030, t1);
        rd_expect("rd30", t1, 1, {54'h0, 18'h15555});

        // Back-to-back reads: command spacing is RD, TURN, IDLE.
        do_cmd(1'b0, 1'b0, 16'h0005, t1);
        do_cmd(1'b0, 1'b0, 16'h0020, t2);
        check_eq("b2b_rd_spacing", t2 - t1, 3);
        rd_expect("b2b_a", t1, 1, {54'h0, 18'h2A5A5});
        rd_expect("b2b_b", t2, 1, {54'h0, 18'h001FF});

        // ZZ sleep for five cycles, then WAKE_CYC=2 cycles before commands.
        wait_ready();
        check_eq("pre_sleep_ready", bus.cmd_ready, 1);
        bus.sleep_req = 1'b1;
        repeat (5) begin
            @(negedge CLK);
            check_eq("sleep_zz_ready", {ZZ, bus.cmd_ready}, 2'b10);
        end
        bus.sleep_req = 1'b0;
        repeat (2) begin
            @(negedge CLK);
            check_eq("wake_zz_ready", {ZZ, bus.cmd_ready}, 2'b00);
        end
        @(negedge CLK);
        check_eq("wake_done_ready", bus.cmd_ready, 1);
        do_cmd(1'b0, 1'b0, 16'h0005, t1);
        rd_expect("rd_post_sleep", t1, 1, {54'h0, 18'h2A5A5});

        // wd_valid while idle is ignored.
        wait_ready();
        bus.wd_valid = 1'b1;
        bus.wd_data  = 18'h12345;
        repeat (2) begin
            @(negedge CLK);
            check_eq("idle_wd_ignored", {bus.wd_ready, DQ_oe, BWE_N}, 3'b001);
        end
        bus.wd_valid = 1'b0;

        // Reset in the middle of a read burst.
        do_cmd(1'b0, 1'b1, 16'h0012, t1);
        check_eq("burst_started", {ADSC_N, OE_N}, 2'b00);
        RST = 1'b1;
        @(negedge CLK);
        check_eq("midrst_pins", w_pins, RST_PINS);
        RST = 1'b0;
        @(negedge CLK);
        check_eq("midrst_ready", bus.cmd_ready, 1);
        repeat (6) @(negedge CLK);
        check_eq("midrst_no_rd", q_dat.size(), 0);

        check_eq("oe_dq_exclusive", viol, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
